// File: rtl/key_scan_pkg.sv
// key_scan_pkg: definitions shared by the keypad scanner and the display side.
//   scan_state_e  scanner FSM encoding (DRIVE, SAMPLE, EMIT)
//   KEY_COLS/ROWS default keypad geometry, shared with the display multiplexer
//   clog2()       width helper used for index, counter and key-code widths
package key_scan_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    EMIT   = 2'd2
  } scan_state_e;

  localparam int unsigned KEY_COLS = 5;
  localparam int unsigned KEY_ROWS = 7;

  // Returns at least 1, so a degenerate size still yields a legal vector width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/key_matrix_scanner_if.sv
// key_matrix_scanner_if: key event channel from the scanner to its consumer.
//   key_valid   event pending (master -> slave)
//   key_code    col*ROWS+row of the event (master -> slave)
//   key_release 1 = release event, 0 = press (master -> slave)
//   key_ready   consumer can take the event (slave -> master)
// Handshake: an event transfers on a rising clock edge where key_valid and
// key_ready are both 1. Once key_valid is raised it stays high, and key_code /
// key_release stay constant, until that transfer; key_ready may be driven
// freely and independently of key_valid.
interface key_matrix_scanner_if #(
  parameter int unsigned CW = 6
);
  logic          key_valid;
  logic          key_ready;
  logic [CW-1:0] key_code;
  logic          key_release;

  modport master (output key_valid, output key_code, output key_release, input key_ready);
  modport slave  (input key_valid, input key_code, input key_release, output key_ready);
endinterface

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: debounced state of a single key.
//   clock, reset  system clock, asynchronous active-high reset
//   sample_en     1 during the SAMPLE cycle of this key's column
//   sample        synchronized raw level of the key (1 = closed)
//   stable        debounced key state
//   flip          1 in the SAMPLE cycle in which stable is about to change
// The counter counts consecutive samples that disagree with stable; any
// agreeing sample clears it, so a bounce never accumulates across scans.
module key_debounce_cell
  import key_scan_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_en,
  input  logic sample,
  output logic stable,
  output logic flip
);

  localparam int unsigned CNTW = clog2(DEBOUNCE_SCANS + 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            stable_q, stable_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip     = 1'b0;
    if (sample_en) begin
      if (sample == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNTW'(DEBOUNCE_SCANS - 1)) begin
        stable_d = sample;
        cnt_d    = '0;
        flip     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans a COLS x ROWS keypad one column at a time,
// debounces every key and emits key events on a valid/ready channel.
//   clock, reset  system clock, asynchronous active-high reset
//   row_in        raw row sense, 1 = key at (driven column, row) closed
//   col_out       one-hot active-high column strobe
//   key_any       OR of all debounced key states (registered)
//   state_dbg     current scanner FSM state
//   evt           event channel (key_valid/key_ready/key_code/key_release)
// Macro KEY_RELEASE_EVT_EN: when defined, releases also produce events with
// key_release=1; otherwise releases update the key state silently and
// key_release is tied 0.
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter int unsigned COLS           = KEY_COLS,
  parameter int unsigned ROWS           = KEY_ROWS,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned CW             = clog2(COLS * ROWS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ROWS-1:0]       row_in,
  output logic [COLS-1:0]       col_out,
  output logic                  key_any,
  output scan_state_e           state_dbg,
  key_matrix_scanner_if.master  evt
);

  localparam int unsigned CIW = clog2(COLS);
  localparam int unsigned RIW = clog2(ROWS);
  localparam int unsigned SCW = clog2(SETTLE_CYCLES);
`ifdef KEY_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  scan_state_e          state_q, state_d;
  logic [CIW-1:0]       col_q, col_d;
  logic [RIW-1:0]       row_q, row_d;
  logic [SCW-1:0]       settle_q, settle_d;
  logic [ROWS-1:0]      flip_q, flip_d;     // rows of the current column that flipped
  logic [ROWS-1:0]      press_q, press_d;   // new level of those rows (1 = press)
  logic                 key_any_q;
  logic [ROWS-1:0]      row_s1_q, row_s2_q;
  logic [COLS-1:0]      sample_en_col;
  logic [COLS*ROWS-1:0] stable_all, flip_all;
  logic [ROWS-1:0]      flip_row;
  logic                 emit_evt;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign sample_en_col[c] = (state_q == SAMPLE) && (col_q == CIW'(c));
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      key_debounce_cell #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_cell (
        .clock     (clock),
        .reset     (reset),
        .sample_en (sample_en_col[c]),
        .sample    (row_s2_q[r]),
        .stable    (stable_all[c*ROWS+r]),
        .flip      (flip_all[c*ROWS+r])
      );
    end
  end

  // Only the sampled column's cells can flip, so OR-ing across columns
  // selects that column's flips without a wide mux.
  always_comb begin
    flip_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        flip_row[r] = flip_row[r] | flip_all[c*ROWS+r];
      end
    end
  end

  assign emit_evt = (state_q == EMIT) && flip_q[row_q] && (press_q[row_q] || REL_EN);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    settle_d = settle_q;
    flip_d   = flip_q;
    press_d  = press_q;
    unique case (state_q)
      DRIVE: begin
        if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SAMPLE: begin
        flip_d  = flip_row;
        press_d = row_s2_q;
        row_d   = '0;
        state_d = EMIT;
      end
      EMIT: begin
        // A pending event holds row, column and code until it is accepted.
        if (!emit_evt || evt.key_ready) begin
          if (row_q == RIW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = DRIVE;
            col_d   = (col_q == CIW'(COLS - 1)) ? '0 : col_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = DRIVE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= DRIVE;
      col_q     <= '0;
      row_q     <= '0;
      settle_q  <= '0;
      flip_q    <= '0;
      press_q   <= '0;
      key_any_q <= 1'b0;
      row_s1_q  <= '0;
      row_s2_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      settle_q  <= settle_d;
      flip_q    <= flip_d;
      press_q   <= press_d;
      key_any_q <= |stable_all;
      row_s1_q  <= row_in;
      row_s2_q  <= row_s1_q;
    end
  end

  assign col_out       = {{(COLS-1){1'b0}}, 1'b1} << col_q;
  assign key_any       = key_any_q;
  assign state_dbg     = state_q;
  assign evt.key_valid = emit_evt;
  assign evt.key_code  = CW'(col_q) * CW'(ROWS) + CW'(row_q);
`ifdef KEY_RELEASE_EVT_EN
  assign evt.key_release = emit_evt & ~press_q[row_q];
`else
  assign evt.key_release = 1'b0;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed bench for key_matrix_scanner.
// A keypad model drives row_in from col_out and the keys vector (bit c*7+r).
// Cycle n = number of rising edges since reset was released; outputs are
// sampled on the falling edge.
module tb_key_matrix_scanner;
  import key_scan_pkg::*;

  localparam int unsigned COLS = 5;
  localparam int unsigned ROWS = 7;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- DUT and keypad model ----------------
  logic [ROWS-1:0]      row_in;
  logic [COLS-1:0]      col_out;
  logic                 key_any;
  scan_state_e          state_dbg;
  logic [COLS*ROWS-1:0] keys;

  key_matrix_scanner_if #(.CW(6)) evt_if ();

  key_matrix_scanner dut (
    .clock     (clock),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_any   (key_any),
    .state_dbg (state_dbg),
    .evt       (evt_if)
  );

  always_comb begin
    row_in = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (col_out[c] && keys[c*ROWS+r]) row_in[r] = 1'b1;
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [5:0] exp_q[$];
  int         obs_cyc_q[$];
  logic       obs_rel_q[$];
  int         extra_evts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    exp_q.delete();
    obs_cyc_q.delete();
    obs_rel_q.delete();
    extra_evts = 0;
    reset = 1'b0;
  endtask

  // Advances ncyc cycles, logging every event accepted at the coming edge.
  task automatic run(input int ncyc);
    repeat (ncyc) begin
      @(negedge clock);
      if (evt_if.key_valid && evt_if.key_ready) begin
        obs_cyc_q.push_back(cyc);
        obs_rel_q.push_back(evt_if.key_release);
        if (exp_q.size() > 0) chk("evt_code", 32'(evt_if.key_code), 32'(exp_q.pop_front()));
        else extra_evts++;
      end
    end
  endtask

  task automatic end_of_test(input string tag);
    chk({tag, "_extra_evts"}, 32'(extra_evts), 32'd0);
    chk({tag, "_missing_evts"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned exp_col;
    scan_state_e exp_st;
    keys = '0;
    evt_if.key_ready = 1'b1;

    // 1: idle scan sequence, column period 12, frame 60
    do_reset();
    chk("t1_col_reset", 32'(col_out), 32'h01);
    chk("t1_state_reset", 32'(state_dbg), 32'(DRIVE));
    chk("t1_code_reset", 32'(evt_if.key_code), 32'd0);
    chk("t1_rel_reset", 32'(evt_if.key_release), 32'd0);
    chk("t1_any_reset", 32'(key_any), 32'd0);
    for (int k = 1; k <= 72; k++) begin
      @(negedge clock);
      exp_col = 32'd1 << ((k / 12) % 5);
      exp_st  = ((k % 12) < 4) ? DRIVE : (((k % 12) == 4) ? SAMPLE : EMIT);
      chk("t1_col", 32'(col_out), exp_col);
      chk("t1_state", 32'(state_dbg), 32'(exp_st));
      chk("t1_valid", 32'(evt_issue_free(evt_if.key_valid)), 32'd0);
    end

    // 2: (col2,row3) held: one event, code 17, at EMIT r=3 of the 4th col-2 scan
    keys = '0;
    keys[17] = 1'b1;
    do_reset();
    exp_q.push_back(6'd17);
    run(208);
    chk("t2_any_before", 32'(key_any), 32'd0);
    run(92);
    end_of_test("t2");
    chk("t2_evt_cycle", 32'((obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1), 32'd212);
    chk("t2_evt_rel", 32'((obs_rel_q.size() > 0) ? obs_rel_q[0] : 1'bx), 32'd0);
    chk("t2_any_after", 32'(key_any), 32'd1);

    // 3: bounce of 3 scans, open, bounce of 3 scans again: never an event
    keys = '0;
    do_reset();
    keys[17] = 1'b1;
    run(180);
    chk("t3_any_bounce1", 32'(key_any), 32'd0);
    keys[17] = 1'b0;
    run(120);
    keys[17] = 1'b1;
    run(180);
    keys[17] = 1'b0;
    run(120);
    end_of_test("t3");
    chk("t3_any_end", 32'(key_any), 32'd0);

    // 4: two keys in column 1, ascending row order
    keys = '0;
    keys[7]  = 1'b1;
    keys[12] = 1'b1;
    do_reset();
    exp_q.push_back(6'd7);
    exp_q.push_back(6'd12);
    run(300);
    end_of_test("t4");
    chk("t4_evt0_cycle", 32'((obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1), 32'd197);
    chk("t4_evt1_cycle", 32'((obs_cyc_q.size() > 1) ? obs_cyc_q[1] : -1), 32'd202);

    // 5: stall with an event pending for 20 cycles
    keys = '0;
    keys[17] = 1'b1;
    evt_if.key_ready = 1'b0;
    do_reset();
    run(212);
    chk("t5_valid_raise", 32'(evt_if.key_valid), 32'd1);
    chk("t5_code_raise", 32'(evt_if.key_code), 32'd17);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk("t5_hold_valid", 32'(evt_if.key_valid), 32'd1);
      chk("t5_hold_code", 32'(evt_if.key_code), 32'd17);
      chk("t5_hold_col", 32'(col_out), 32'h04);
    end
    evt_if.key_ready = 1'b1;
    @(negedge clock);
    chk("t5_accept_valid", 32'(evt_if.key_valid), 32'd0);
    chk("t5_accept_col", 32'(col_out), 32'h04);
    repeat (3) @(negedge clock);
    chk("t5_resume_col", 32'(col_out), 32'h08);
    chk("t5_resume_valid", 32'(evt_if.key_valid), 32'd0);
    chk("t5_any", 32'(key_any), 32'd1);

    // 6: release of (col2,row3)
    keys[17] = 1'b0;
    exp_q.delete();
    obs_cyc_q.delete();
    obs_rel_q.delete();
    extra_evts = 0;
    chk("t6_any_before", 32'(key_any), 32'd1);
`ifdef KEY_RELEASE_EVT_EN
    exp_q.push_back(6'd17);
`endif
    run(300);
    end_of_test("t6");
`ifdef KEY_RELEASE_EVT_EN
    chk("t6_evt_rel", 32'((obs_rel_q.size() > 0) ? obs_rel_q[0] : 1'bx), 32'd1);
`endif
    chk("t6_any_after", 32'(key_any), 32'd0);

    // 7: reset while an event is pending
    keys = '0;
    keys[17] = 1'b1;
    evt_if.key_ready = 1'b0;
    do_reset();
    run(212);
    chk("t7_valid_pre", 32'(evt_if.key_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_col", 32'(col_out), 32'h01);
    chk("t7_valid", 32'(evt_if.key_valid), 32'd0);
    chk("t7_code", 32'(evt_if.key_code), 32'd0);
    chk("t7_rel", 32'(evt_if.key_release), 32'd0);
    chk("t7_any", 32'(key_any), 32'd0);
    chk("t7_state", 32'(state_dbg), 32'(DRIVE));
    @(negedge clock);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Identity helper so the idle-valid check reads as a plain sampled value.
  function automatic logic evt_issue_free(input logic v);
    return v;
  endfunction

endmodule
